fifo_status_arb: RTL and testbench
==================================

# fifo_status_arb

Multi-channel, parametrised successor to the single-FIFO status controller. It watches the fill level and tail events of CH_NUM write-side FIFOs and arbitrates them round-robin onto one shared burst-request interface toward the AXI write master. It issues full bursts or tail (partial) bursts with per-request length and channel tag. A programmable timeout aborts a stuck transfer and requests a per-channel chain reset.

## Interface
- CH_NUM, 4: number of FIFO channels, 1..16.
- CNT_W, 10: width of each channel's FIFO count.
- LSIZE, 9: width of burst length fields.
- THRESHOLD, 200: count level (>=) at which a channel needs a full burst.
- BURST_LEN, 100: length issued for a full burst; must be ≤ THRESHOLD.
- TIMEOUT_CYC, 16'hFFF0: cycles allowed in REQ+WAIT_DONE before abort; 0 disables the timeout.
- MODE, "LINE": "LINE" means line_tail edges arm tails; "ONCE" means frame_tail edges arm tails.

- clock  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  global grant enable; an in-flight transfer still completes when it drops.
- f_rst_status  in  CH_NUM  per-channel soft reset.
- count  in  CH_NUM*CNT_W  FIFO counts; channel i occupies [i*CNT_W +: CNT_W].
- line_tail, frame_tail  in  CH_NUM each  tail markers, level signals.
- tail_len  in  CH_NUM*LSIZE  tail lengths, packed the same way as count.
- fifo_empty  in  CH_NUM  FIFO empty flags.
- req  out  1  request valid.
- req_tail  out  1  current request is a tail burst.
- req_ch  out  $clog2(CH_NUM) (minimum 1)  granted channel.
- req_len  out  LSIZE  granted length.
- resp  in  1  master accepted the request.
- done  in  1  master finished the burst.
- burst_done, tail_done  out  CH_NUM each  one-cycle completion pulses.
- rst_chain  out  CH_NUM  one-cycle abort pulse.
- timeout_err  out  1  sticky timeout flag; cleared only by rst_n.

## Operation
- **Tail arming:** each channel keeps tail_pend[i].
  - Set on the rising edge of the selected tail input. The edge is detected against a registered copy of the input, so it takes effect one cycle late.
  - Cleared on tail completion (FSH with req_tail=1), on f_rst_status[i], or when the channel is evaluated in IDLE with count==0.
- **Eligibility in IDLE:** channel i is eligible when enable=1, fifo_empty[i]=0, and either tail_pend[i]=1 or count_i ≥ THRESHOLD.
  - Tail takes priority over a full burst within a channel.
- **Arbitration:** round-robin. Search starts at last_grant+1 and wraps modulo CH_NUM. After reset last_grant=CH_NUM-1, so channel 0 is searched first.
- **FSM:** IDLE → REQ → WAIT_DONE → FSH → IDLE; abort path is TIME_ERR → FLUSH → IDLE.
  - IDLE→REQ on any eligible channel. At the same edge, latch req_ch, req_tail, and req_len (BURST_LEN, or tail_len[ch] for a tail) and update last_grant.
  - REQ: resp=1 → WAIT_DONE. If resp and done are both 1 in the same cycle → FSH directly.
  - WAIT_DONE: done=1 → FSH.
  - FSH: pulse burst_done[ch] or tail_done[ch] for one cycle, then IDLE.
  - TIME_ERR: pulse rst_chain[ch], set timeout_err, clear tail_pend[ch], then FLUSH.
  - FLUSH: wait for fifo_empty[ch]=1, then IDLE.
- **Soft reset of the granted channel:** f_rst_status[ch] in any non-IDLE state forces IDLE at the next edge. No done pulse and no rst_chain are issued for that transfer.
- **Soft reset of other channels:** f_rst_status on a channel that is not granted only clears its tail_pend.
- **Timeout counter (16-bit, saturating):**
  - Cleared on entry to REQ and on resp.
  - Increments in REQ and WAIT_DONE.
  - When it reaches TIMEOUT_CYC, the FSM goes to TIME_ERR. A done arriving in the same cycle wins and the FSM goes to FSH.
- **Reset values:** req, req_tail, burst_done, tail_done, rst_chain and timeout_err are 0; req_ch and req_len are 0; all tail_pend bits are 0; state is IDLE.

## Timing
- All outputs are registered.
- req rises at the edge the FSM enters REQ and stays high, level-held, until the edge after resp is sampled.
- req_ch, req_len and req_tail are stable from the grant edge until the next grant.
- Minimum grant-to-grant spacing is 4 cycles (REQ, WAIT_DONE, FSH, IDLE), or 3 cycles when resp and done coincide.
- Tail input edge to earliest req is 3 cycles: edge register, tail_pend, then the IDLE grant.
- The count and fifo_empty samples in IDLE are combinational with the current cycle. A channel going empty in the same cycle as its grant is still granted.

## Test plan
- CH_NUM=4, count0=200, others 0, resp two cycles after req, done five cycles later → one request with req_ch=0, req_len=100, req_tail=0, then one burst_done[0] pulse, then IDLE.
- Channels 1 and 3 both at count 250 and re-armed after each completion → grants alternate 1, 3, 1, 3, with no channel granted twice in a row while the other is eligible.
- MODE="LINE", line_tail[2] rises, count2=37, tail_len2=37 → req_tail=1, req_ch=2, req_len=37; tail_done[2] pulses; tail_pend[2] clears.
- line_tail[1] rises while count1=0 → tail_pend[1] clears in IDLE and no request is issued.
- TIMEOUT_CYC=64, resp withheld → TIME_ERR at cycle 64 after REQ entry, then a rst_chain[ch] pulse and timeout_err=1; FLUSH holds until fifo_empty[ch]=1 is forced, then IDLE.
- f_rst_status[ch] asserted during WAIT_DONE → IDLE next cycle with no done pulse; the next eligible channel is granted afterwards.

Source files
------------

// File: rtl/fifo_status_arb.sv
// fifo_status_arb: round-robin burst-request arbiter over CH_NUM write-side FIFOs.
// Watches fill levels and tail events and issues full or tail bursts to one shared
// request interface. A stuck transfer can be aborted by a timeout, which pulses a
// per-channel chain reset.
module fifo_status_arb #(
   parameter int unsigned CH_NUM      = 4,
   parameter int unsigned CNT_W       = 10,
   parameter int unsigned LSIZE       = 9,
   parameter int unsigned THRESHOLD   = 200,
   parameter int unsigned BURST_LEN   = 100,
   parameter logic [15:0] TIMEOUT_CYC = 16'hFFF0,
   parameter string       MODE        = "LINE",
   localparam int unsigned CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
   input  logic                      clock,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [CH_NUM-1:0]         f_rst_status,
   input  logic [CH_NUM*CNT_W-1:0]   count,
   input  logic [CH_NUM-1:0]         line_tail,
   input  logic [CH_NUM-1:0]         frame_tail,
   input  logic [CH_NUM*LSIZE-1:0]   tail_len,
   input  logic [CH_NUM-1:0]         fifo_empty,
   output logic                      req,
   output logic                      req_tail,
   output logic [CH_W-1:0]           req_ch,
   output logic [LSIZE-1:0]          req_len,
   input  logic                      resp,
   input  logic                      done,
   output logic [CH_NUM-1:0]         burst_done,
   output logic [CH_NUM-1:0]         tail_done,
   output logic [CH_NUM-1:0]         rst_chain,
   output logic                      timeout_err
);

   localparam int unsigned TMO_W     = 16;
   localparam bit          USE_FRAME = (MODE == "ONCE");

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_FSH   = 3'd3;
   localparam logic [2:0] S_TERR  = 3'd4;
   localparam logic [2:0] S_FLUSH = 3'd5;

   // state and datapath registers
   logic [2:0]         state_q,      state_d;
   logic [CH_W-1:0]    ch_q,         ch_d;
   logic [CH_W-1:0]    last_q,       last_d;
   logic               tail_q,       tail_d;
   logic [LSIZE-1:0]   len_q,        len_d;
   logic               req_q,        req_d;
   logic [TMO_W-1:0]   tmo_q,        tmo_d;
   logic [CH_NUM-1:0]  pend_q,       pend_d;
   logic [CH_NUM-1:0]  tail_in_q;
   logic [CH_NUM-1:0]  edge_q;
   logic [CH_NUM-1:0]  burst_done_q, burst_done_d;
   logic [CH_NUM-1:0]  tail_done_q,  tail_done_d;
   logic [CH_NUM-1:0]  rst_chain_q,  rst_chain_d;
   logic               terr_q,       terr_d;

   // combinational helpers
   logic [CH_NUM-1:0]  tail_sel;
   logic [CH_NUM-1:0]  elig;
   logic [CH_NUM-1:0]  cnt_zero;
   logic [CH_NUM-1:0]  ch_oh;
   logic               gnt_found;
   logic [CH_W-1:0]    gnt_ch;
   logic [TMO_W-1:0]   tmo_inc;
   logic               tmo_hit;

   logic [CNT_W-1:0]   cnt_a  [CH_NUM];
   logic [LSIZE-1:0]   tlen_a [CH_NUM];

   // unpack per-channel count and tail length buses
   for (genvar g = 0; g < CH_NUM; g++) begin : g_unpack
      assign cnt_a[g]  = count[g*CNT_W +: CNT_W];
      assign tlen_a[g] = tail_len[g*LSIZE +: LSIZE];
   end

   assign tail_sel = USE_FRAME ? frame_tail : line_tail;
   assign ch_oh    = CH_NUM'(1) << ch_q;

   // per-channel eligibility: tail pending or fill level at threshold
   always_comb begin
      elig     = '0;
      cnt_zero = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         cnt_zero[i] = (cnt_a[i] == '0);
         elig[i]     = enable & ~fifo_empty[i] &
                       (pend_q[i] | (cnt_a[i] >= CNT_W'(THRESHOLD)));
      end
   end

   // round-robin search starting one past the last grant
   always_comb begin
      int unsigned pos;
      logic [CH_W-1:0] cand;
      pos       = 0;
      cand      = '0;
      gnt_found = 1'b0;
      gnt_ch    = '0;
      for (int unsigned k = 1; k <= CH_NUM; k++) begin
         pos = 32'(last_q) + k;
         if (pos >= CH_NUM) begin
            pos = pos - CH_NUM;
         end
         cand = CH_W'(pos);
         if (!gnt_found && elig[cand]) begin
            gnt_found = 1'b1;
            gnt_ch    = cand;
         end
      end
   end

   // saturating timeout increment and abort condition
   always_comb begin
      tmo_inc = (tmo_q == {TMO_W{1'b1}}) ? tmo_q : tmo_q + TMO_W'(1);
      tmo_hit = (TIMEOUT_CYC != '0) && (tmo_inc == TIMEOUT_CYC);
   end

   // next-state, grant latching and registered-output decode
   always_comb begin
      state_d      = state_q;
      ch_d         = ch_q;
      last_d       = last_q;
      tail_d       = tail_q;
      len_d        = len_q;
      tmo_d        = tmo_q;
      req_d        = 1'b0;
      burst_done_d = '0;
      tail_done_d  = '0;
      rst_chain_d  = '0;
      terr_d       = terr_q;

      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               state_d = S_REQ;
               ch_d    = gnt_ch;
               last_d  = gnt_ch;
               tail_d  = pend_q[gnt_ch];
               len_d   = pend_q[gnt_ch] ? tlen_a[gnt_ch] : LSIZE'(BURST_LEN);
               tmo_d   = '0;
            end
         end
         S_REQ: begin
            if (resp) begin
               tmo_d   = '0;
               state_d = done ? S_FSH : S_WAIT;
            end else begin
               tmo_d = tmo_inc;
               if (tmo_hit) begin
                  state_d = S_TERR;
               end
            end
         end
         S_WAIT: begin
            tmo_d = tmo_inc;
            if (done) begin
               state_d = S_FSH;
            end else if (tmo_hit) begin
               state_d = S_TERR;
            end
         end
         S_FSH: begin
            state_d = S_IDLE;
         end
         S_TERR: begin
            state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (fifo_empty[ch_q]) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // soft reset of the granted channel abandons the transfer silently
      if ((state_q != S_IDLE) && f_rst_status[ch_q]) begin
         state_d = S_IDLE;
      end

      // outputs are decoded from the next state so they line up with it
      req_d = (state_d == S_REQ);
      if (state_d == S_FSH) begin
         if (tail_q) begin
            tail_done_d = ch_oh;
         end else begin
            burst_done_d = ch_oh;
         end
      end
      if (state_d == S_TERR) begin
         rst_chain_d = ch_oh;
         terr_d      = 1'b1;
      end
   end

   // tail-pending bookkeeping; a fresh edge beats completion, soft reset beats all
   always_comb begin
      pend_d = pend_q;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if ((state_q == S_IDLE) && cnt_zero[i]) begin
            pend_d[i] = 1'b0;
         end
         if ((state_q == S_FSH) && tail_q && (ch_q == CH_W'(i))) begin
            pend_d[i] = 1'b0;
         end
         if ((state_q == S_TERR) && (ch_q == CH_W'(i))) begin
            pend_d[i] = 1'b0;
         end
         if (edge_q[i]) begin
            pend_d[i] = 1'b1;
         end
         if (f_rst_status[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // state and output registers, synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         ch_q         <= '0;
         last_q       <= CH_W'(CH_NUM - 1);
         tail_q       <= 1'b0;
         len_q        <= '0;
         req_q        <= 1'b0;
         tmo_q        <= '0;
         pend_q       <= '0;
         tail_in_q    <= '0;
         edge_q       <= '0;
         burst_done_q <= '0;
         tail_done_q  <= '0;
         rst_chain_q  <= '0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         last_q       <= last_d;
         tail_q       <= tail_d;
         len_q        <= len_d;
         req_q        <= req_d;
         tmo_q        <= tmo_d;
         pend_q       <= pend_d;
         tail_in_q    <= tail_sel;
         edge_q       <= tail_sel & ~tail_in_q;
         burst_done_q <= burst_done_d;
         tail_done_q  <= tail_done_d;
         rst_chain_q  <= rst_chain_d;
         terr_q       <= terr_d;
      end
   end

   assign req         = req_q;
   assign req_tail    = tail_q;
   assign req_ch      = ch_q;
   assign req_len     = len_q;
   assign burst_done  = burst_done_q;
   assign tail_done   = tail_done_q;
   assign rst_chain   = rst_chain_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_fifo_status_arb.sv
// Directed bench for fifo_status_arb: full bursts, round-robin, tails, timeout, soft reset.
module tb_fifo_status_arb;

   localparam int unsigned CH_NUM = 4;
   localparam int unsigned CNT_W  = 10;
   localparam int unsigned LSIZE  = 9;
   localparam int unsigned CH_W   = 2;

   logic                    clock = 1'b0;
   logic                    rst_n;
   logic                    enable;
   logic [CH_NUM-1:0]       f_rst_status;
   logic [CH_NUM*CNT_W-1:0] count;
   logic [CH_NUM-1:0]       line_tail;
   logic [CH_NUM-1:0]       frame_tail;
   logic [CH_NUM*LSIZE-1:0] tail_len;
   logic [CH_NUM-1:0]       fifo_empty;
   logic                    req;
   logic                    req_tail;
   logic [CH_W-1:0]         req_ch;
   logic [LSIZE-1:0]        req_len;
   logic                    resp;
   logic                    done;
   logic [CH_NUM-1:0]       burst_done;
   logic [CH_NUM-1:0]       tail_done;
   logic [CH_NUM-1:0]       rst_chain;
   logic                    timeout_err;

   int n_tests = 0;
   int n_fail  = 0;

   fifo_status_arb #(
      .CH_NUM      (CH_NUM),
      .CNT_W       (CNT_W),
      .LSIZE       (LSIZE),
      .THRESHOLD   (200),
      .BURST_LEN   (100),
      .TIMEOUT_CYC (16'd64),
      .MODE        ("LINE")
   ) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .enable       (enable),
      .f_rst_status (f_rst_status),
      .count        (count),
      .line_tail    (line_tail),
      .frame_tail   (frame_tail),
      .tail_len     (tail_len),
      .fifo_empty   (fifo_empty),
      .req          (req),
      .req_tail     (req_tail),
      .req_ch       (req_ch),
      .req_len      (req_len),
      .resp         (resp),
      .done         (done),
      .burst_done   (burst_done),
      .tail_done    (tail_done),
      .rst_chain    (rst_chain),
      .timeout_err  (timeout_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic set_cnt(input int ch, input int val);
      count[ch*CNT_W +: CNT_W] = CNT_W'(val);
   endtask

   task automatic set_tlen(input int ch, input int val);
      tail_len[ch*LSIZE +: LSIZE] = LSIZE'(val);
   endtask

   // wait (bounded) for req, reporting how many edges it took
   task automatic wait_req(input string tag, input int max_cyc, output int cyc);
      cyc = 0;
      while (req !== 1'b1 && cyc < max_cyc) begin
         tick();
         cyc++;
      end
      check_val({tag, "_req"}, 32'(req), 32'd1);
   endtask

   // resp after rd edges, done dd edges after resp; returns at the FSH sample
   task automatic serve(input int rd, input int dd);
      repeat (rd) tick();
      resp = 1'b1;
      tick();
      resp = 1'b0;
      repeat (dd - 1) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      int n;
      bit run;
      int exp_seq [4];
      exp_seq = '{1, 3, 1, 3};

      rst_n        = 1'b0;
      enable       = 1'b0;
      f_rst_status = '0;
      count        = '0;
      line_tail    = '0;
      frame_tail   = '0;
      tail_len     = '0;
      fifo_empty   = '1;
      resp         = 1'b0;
      done         = 1'b0;
      repeat (3) tick();

      // reset values
      check_val("rst_req",        32'(req),         32'd0);
      check_val("rst_req_tail",   32'(req_tail),    32'd0);
      check_val("rst_req_ch",     32'(req_ch),      32'd0);
      check_val("rst_req_len",    32'(req_len),     32'd0);
      check_val("rst_burst_done", 32'(burst_done),  32'd0);
      check_val("rst_tail_done",  32'(tail_done),   32'd0);
      check_val("rst_chain",      32'(rst_chain),   32'd0);
      check_val("rst_timeout",    32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      tick();

      // single full burst on channel 0
      enable        = 1'b1;
      set_cnt(0, 200);
      fifo_empty[0] = 1'b0;
      wait_req("t1", 10, cyc);
      check_val("t1_latency",  32'(cyc),      32'd1);
      check_val("t1_req_ch",   32'(req_ch),   32'd0);
      check_val("t1_req_len",  32'(req_len),  32'd100);
      check_val("t1_req_tail", 32'(req_tail), 32'd0);
      set_cnt(0, 0);
      fifo_empty[0] = 1'b1;
      tick();
      tick();
      check_val("t1_req_held", 32'(req), 32'd1);
      resp = 1'b1;
      tick();
      resp = 1'b0;
      check_val("t1_req_drop", 32'(req), 32'd0);
      repeat (4) tick();
      check_val("t1_no_early_done", 32'(burst_done), 32'd0);
      done = 1'b1;
      tick();
      done = 1'b0;
      check_val("t1_burst_done", 32'(burst_done), 32'h1);
      check_val("t1_tail_done",  32'(tail_done),  32'h0);
      tick();
      check_val("t1_done_1cyc", 32'(burst_done), 32'd0);
      repeat (4) tick();
      check_val("t1_idle", 32'(req), 32'd0);

      // enable low blocks grants
      enable = 1'b0;
      set_cnt(1, 250);
      set_cnt(3, 250);
      fifo_empty[1] = 1'b0;
      fifo_empty[3] = 1'b0;
      repeat (5) tick();
      check_val("en_off_no_req", 32'(req), 32'd0);

      // round-robin between channels 1 and 3
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_req($sformatf("t2_g%0d", i), 12, cyc);
         if (i > 0) begin
            check_val($sformatf("t2_spacing%0d", i), 32'(cyc), 32'd2);
         end
         check_val($sformatf("t2_ch%0d", i),   32'(req_ch),   32'(exp_seq[i]));
         check_val($sformatf("t2_tail%0d", i), 32'(req_tail), 32'd0);
         serve(1, 2);
         check_val($sformatf("t2_done%0d", i), 32'(burst_done), 32'd1 << exp_seq[i]);
      end
      set_cnt(1, 0);
      set_cnt(3, 0);
      fifo_empty[1] = 1'b1;
      fifo_empty[3] = 1'b1;
      repeat (5) tick();
      check_val("t2_idle", 32'(req), 32'd0);

      // line tail on channel 2
      set_cnt(2, 37);
      set_tlen(2, 37);
      fifo_empty[2] = 1'b0;
      line_tail[2]  = 1'b1;
      wait_req("t3", 10, cyc);
      check_val("t3_latency",  32'(cyc),      32'd3);
      check_val("t3_req_tail", 32'(req_tail), 32'd1);
      check_val("t3_req_ch",   32'(req_ch),   32'd2);
      check_val("t3_req_len",  32'(req_len),  32'd37);
      serve(0, 1);
      check_val("t3_tail_done",  32'(tail_done),  32'h4);
      check_val("t3_burst_done", 32'(burst_done), 32'h0);
      repeat (6) tick();
      check_val("t3_pend_cleared", 32'(req), 32'd0);
      line_tail[2]  = 1'b0;
      set_cnt(2, 0);
      fifo_empty[2] = 1'b1;

      // tail edge on an empty channel is dropped in IDLE
      line_tail[1] = 1'b1;
      repeat (6) tick();
      check_val("t4_no_req", 32'(req), 32'd0);
      set_cnt(1, 5);
      fifo_empty[1] = 1'b0;
      repeat (5) tick();
      check_val("t4_pend_gone", 32'(req), 32'd0);
      set_cnt(1, 0);
      fifo_empty[1] = 1'b1;
      line_tail[1]  = 1'b0;

      // timeout with resp withheld on channel 0
      set_cnt(0, 200);
      fifo_empty[0] = 1'b0;
      wait_req("t5", 10, cyc);
      check_val("t5_req_ch", 32'(req_ch), 32'd0);
      n   = 1;
      run = 1'b1;
      while (run && n < 200) begin
         tick();
         if (req === 1'b1) n++;
         else run = 1'b0;
      end
      check_val("t5_req_cycles",  32'(n),           32'd64);
      check_val("t5_rst_chain",   32'(rst_chain),   32'h1);
      check_val("t5_timeout_err", 32'(timeout_err), 32'd1);
      set_cnt(0, 0);
      set_cnt(3, 220);
      fifo_empty[3] = 1'b0;
      tick();
      check_val("t5_chain_1cyc", 32'(rst_chain), 32'd0);
      repeat (5) tick();
      check_val("t5_flush_hold", 32'(req), 32'd0);
      fifo_empty[0] = 1'b1;
      wait_req("t5_post", 10, cyc);
      check_val("t5_post_latency", 32'(cyc),         32'd2);
      check_val("t5_post_ch",      32'(req_ch),      32'd3);
      check_val("t5_sticky",       32'(timeout_err), 32'd1);

      // soft reset of granted channel 3 during WAIT_DONE
      resp = 1'b1;
      tick();
      resp = 1'b0;
      check_val("t6_wait", 32'(req), 32'd0);
      f_rst_status[3] = 1'b1;
      set_cnt(3, 0);
      fifo_empty[3] = 1'b1;
      set_cnt(1, 300);
      fifo_empty[1] = 1'b0;
      tick();
      f_rst_status[3] = 1'b0;
      check_val("t6_no_burst_done", 32'(burst_done), 32'd0);
      check_val("t6_no_tail_done",  32'(tail_done),  32'd0);
      check_val("t6_no_rst_chain",  32'(rst_chain),  32'd0);
      wait_req("t6_next", 10, cyc);
      check_val("t6_next_latency", 32'(cyc),    32'd1);
      check_val("t6_next_ch",      32'(req_ch), 32'd1);

      // resp and done together, then 3-cycle grant spacing
      resp = 1'b1;
      done = 1'b1;
      tick();
      resp = 1'b0;
      done = 1'b0;
      check_val("t7_burst_done", 32'(burst_done), 32'h2);
      check_val("t7_req_low",    32'(req),        32'd0);
      wait_req("t7_regrant", 10, cyc);
      check_val("t7_spacing", 32'(cyc),    32'd2);
      check_val("t7_ch",      32'(req_ch), 32'd1);
      set_cnt(1, 0);
      fifo_empty[1] = 1'b1;
      serve(0, 1);
      check_val("t7_done2", 32'(burst_done), 32'h2);
      repeat (4) tick();
      check_val("t7_idle", 32'(req), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
